// File: rtl/axis_packet_accumulator.sv
// AXI-Stream packet accumulator: sums strobe-masked beats per tlast-delimited packet,
// counts beats and presents each result on a valid/ready port while stalling the stream.
module axis_packet_accumulator #(
    parameter int DATA_SIZE = 32,
    parameter int SUM_SIZE  = 40,
    parameter int MAX_WORDS = 16,
    parameter int CNT_SIZE  = $clog2(MAX_WORDS + 1)
) (
    input  logic                   s00_axis_aclk,
    input  logic                   s00_axis_areset,
    input  logic                   s00_axis_enable,
    input  logic [DATA_SIZE-1:0]   s00_axis_tdata,
    input  logic [DATA_SIZE/8-1:0] s00_axis_tstrb,
    input  logic                   s00_axis_tvalid,
    input  logic                   s00_axis_tlast,
    output logic                   s00_axis_tready,
    output logic [SUM_SIZE-1:0]    res_sum,
    output logic [CNT_SIZE-1:0]    res_count,
    output logic                   res_overflow,
    output logic                   res_truncated,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [15:0]            pkt_total
);

    localparam int STRB_SIZE = DATA_SIZE / 8;

    typedef enum logic [1:0] {StIdle, StAccum, StHold} state_t;

    state_t               state_q, state_d;
    logic [SUM_SIZE-1:0]  acc_q, acc_d;
    logic [CNT_SIZE-1:0]  cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;
    logic                 res_valid_q, res_valid_d;
    logic [15:0]          pkt_total_q, pkt_total_d;
    logic [SUM_SIZE-1:0]  res_sum_q;
    logic [CNT_SIZE-1:0]  res_count_q;
    logic                 res_overflow_q;
    logic                 res_truncated_q;

    logic [DATA_SIZE-1:0] masked;
    logic [SUM_SIZE-1:0]  acc_base;
    logic [CNT_SIZE-1:0]  cnt_base;
    logic                 ovf_base;
    logic [SUM_SIZE:0]    sum_full;
    logic [CNT_SIZE-1:0]  cnt_next;
    logic                 ovf_next;
    logic                 accept;
    logic                 close;
    logic                 res_load;

    // Reset term keeps tready low while reset is held, so every output reads 0.
    assign s00_axis_tready = s00_axis_enable && (state_q != StHold) && !s00_axis_areset;
    assign accept          = s00_axis_tvalid && s00_axis_tready;

    always_comb begin
        masked = '0;
        for (int i = 0; i < STRB_SIZE; i++) begin
            if (s00_axis_tstrb[i]) begin
                masked[8*i +: 8] = s00_axis_tdata[8*i +: 8];
            end
        end
    end

    // First beat of a packet loads from zero rather than from the held registers.
    always_comb begin
        if (state_q == StIdle) begin
            acc_base = '0;
            cnt_base = '0;
            ovf_base = 1'b0;
        end else begin
            acc_base = acc_q;
            cnt_base = cnt_q;
            ovf_base = ovf_q;
        end
        sum_full = {1'b0, acc_base} + {1'b0, SUM_SIZE'(masked)};
        cnt_next = cnt_base + CNT_SIZE'(1);
        ovf_next = ovf_base | sum_full[SUM_SIZE];
        close    = s00_axis_tlast || (cnt_next == CNT_SIZE'(MAX_WORDS));
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        res_valid_d = res_valid_q;
        pkt_total_d = pkt_total_q;
        res_load    = 1'b0;
        unique case (state_q)
            StIdle, StAccum: begin
                if (accept) begin
                    if (close) begin
                        state_d     = StHold;
                        acc_d       = '0;
                        cnt_d       = '0;
                        ovf_d       = 1'b0;
                        res_valid_d = 1'b1;
                        pkt_total_d = pkt_total_q + 16'd1;
                        res_load    = 1'b1;
                    end else begin
                        state_d = StAccum;
                        acc_d   = sum_full[SUM_SIZE-1:0];
                        cnt_d   = cnt_next;
                        ovf_d   = ovf_next;
                    end
                end
            end
            StHold: begin
                if (res_valid_q && res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            res_valid_q <= 1'b0;
            pkt_total_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            res_valid_q <= res_valid_d;
            pkt_total_q <= pkt_total_d;
        end
    end

    // Result data holds its last value after the handshake; only a close reloads it.
    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) begin
            res_sum_q       <= '0;
            res_count_q     <= '0;
            res_overflow_q  <= 1'b0;
            res_truncated_q <= 1'b0;
        end else if (res_load) begin
            res_sum_q       <= sum_full[SUM_SIZE-1:0];
            res_count_q     <= cnt_next;
            res_overflow_q  <= ovf_next;
            res_truncated_q <= !s00_axis_tlast;
        end
    end

    assign res_sum       = res_sum_q;
    assign res_count     = res_count_q;
    assign res_overflow  = res_overflow_q;
    assign res_truncated = res_truncated_q;
    assign res_valid     = res_valid_q;
    assign pkt_total     = pkt_total_q;

endmodule

// File: tb/tb_axis_packet_accumulator.sv
// Bench for axis_packet_accumulator: a 40-bit and a 32-bit accumulator share one stream;
// expected results are queued at stimulus time and checked by a monitor at each handshake.
module tb_axis_packet_accumulator;

    logic        clk = 1'b0;
    logic        areset;
    logic        enable;
    logic [31:0] tdata;
    logic [3:0]  tstrb;
    logic        tvalid;
    logic        tlast;
    logic        res_ready;

    logic        tready_a, tready_b;
    logic [39:0] sum_a;
    logic [31:0] sum_b;
    logic [4:0]  count_a, count_b;
    logic        ovf_a, ovf_b, trunc_a, trunc_b, valid_a, valid_b;
    logic [15:0] total_a, total_b;

    axis_packet_accumulator #(.DATA_SIZE(32), .SUM_SIZE(40), .MAX_WORDS(16)) dut_a (
        .s00_axis_aclk(clk), .s00_axis_areset(areset), .s00_axis_enable(enable),
        .s00_axis_tdata(tdata), .s00_axis_tstrb(tstrb), .s00_axis_tvalid(tvalid),
        .s00_axis_tlast(tlast), .s00_axis_tready(tready_a),
        .res_sum(sum_a), .res_count(count_a), .res_overflow(ovf_a),
        .res_truncated(trunc_a), .res_valid(valid_a), .res_ready(res_ready),
        .pkt_total(total_a)
    );

    axis_packet_accumulator #(.DATA_SIZE(32), .SUM_SIZE(32), .MAX_WORDS(16)) dut_b (
        .s00_axis_aclk(clk), .s00_axis_areset(areset), .s00_axis_enable(enable),
        .s00_axis_tdata(tdata), .s00_axis_tstrb(tstrb), .s00_axis_tvalid(tvalid),
        .s00_axis_tlast(tlast), .s00_axis_tready(tready_b),
        .res_sum(sum_b), .res_count(count_b), .res_overflow(ovf_b),
        .res_truncated(trunc_b), .res_valid(valid_b), .res_ready(res_ready),
        .pkt_total(total_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [39:0] sum40;
        logic [31:0] sum32;
        logic        ovf40;
        logic        ovf32;
        logic [4:0]  cnt;
        logic        trunc;
        logic [15:0] total;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_pkt(input logic [39:0] s40, input logic [31:0] s32, input logic o40,
                              input logic o32, input logic [4:0] c, input logic t,
                              input logic [15:0] tot);
        exp_t e;
        e.sum40 = s40; e.sum32 = s32; e.ovf40 = o40; e.ovf32 = o32;
        e.cnt = c; e.trunc = t; e.total = tot;
        exp_q.push_back(e);
    endtask

    // Present a beat and hold it until accepted; returns 1 time unit after the accepting edge.
    task automatic send_beat(input logic [31:0] d, input logic [3:0] s, input logic l);
        int budget;
        budget = 0;
        tdata = d; tstrb = s; tlast = l; tvalid = 1'b1;
        do begin
            @(negedge clk);
            budget++;
        end while (!tready_a && budget < 60);
        if (!tready_a) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: got tready=0, expected 1 within 60 cycles");
        end
        @(posedge clk);
        #1;
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tready"}, 64'(tready_a), 64'd0);
        check({tag, "_valid"},  64'({valid_a, valid_b}), 64'd0);
        check({tag, "_sum"},    64'(sum_a), 64'd0);
        check({tag, "_count"},  64'(count_a), 64'd0);
        check({tag, "_flags"},  64'({ovf_a, trunc_a}), 64'd0);
        check({tag, "_total"},  64'(total_a), 64'd0);
    endtask

    // Monitor: one comparison set per result handshake.
    always @(negedge clk) begin
        if (valid_a && res_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_result: got sum 0x%0h, expected no result", sum_a);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sum40",   64'(sum_a),   64'(e.sum40));
                check("sum32",   64'(sum_b),   64'(e.sum32));
                check("ovf40",   64'(ovf_a),   64'(e.ovf40));
                check("ovf32",   64'(ovf_b),   64'(e.ovf32));
                check("count",   64'(count_a), 64'(e.cnt));
                check("trunc",   64'(trunc_a), 64'(e.trunc));
                check("total",   64'(total_a), 64'(e.total));
                check("valid32", 64'(valid_b), 64'd1);
            end
        end
    end

    initial begin
        areset = 1'b1; enable = 1'b1; res_ready = 1'b1;
        tdata = '0; tstrb = '0; tvalid = 1'b0; tlast = 1'b0;
        #2;
        check_all_zero("reset");
        @(posedge clk); #3;
        areset = 1'b0;
        @(posedge clk); #1;

        // Four plain beats, then a one-cycle result and a one-cycle tready bubble.
        expect_pkt(40'd10, 32'd10, 1'b0, 1'b0, 5'd4, 1'b0, 16'd1);
        send_beat(32'h1, 4'hF, 1'b0);
        send_beat(32'h2, 4'hF, 1'b0);
        send_beat(32'h3, 4'hF, 1'b0);
        send_beat(32'h4, 4'hF, 1'b1);
        check("t1_valid_hi", 64'(valid_a), 64'd1);
        check("t1_bubble", 64'(tready_a), 64'd0);
        @(posedge clk); #1;
        check("t1_valid_lo", 64'(valid_a), 64'd0);
        check("t1_tready_back", 64'(tready_a), 64'd1);

        // Strobe masking keeps only bytes 0 and 2 of the first beat.
        expect_pkt(40'h0011DD3421, 32'h11DD3421, 1'b0, 1'b0, 5'd2, 1'b0, 16'd2);
        send_beat(32'hAABBCCDD, 4'h5, 1'b0);
        send_beat(32'h11223344, 4'hF, 1'b1);
        @(posedge clk); #1;

        // Forced close at 16 beats; the 32-bit instance wraps.
        expect_pkt(40'hFFFFFFFF0, 32'hFFFFFFF0, 1'b0, 1'b1, 5'd16, 1'b1, 16'd3);
        for (int i = 0; i < 16; i++) send_beat(32'hFFFFFFFF, 4'hF, 1'b0);
        check("t3_closed", 64'(valid_a), 64'd1);
        @(posedge clk); #1;

        // Consumer stalls for 10 cycles while the next beat waits upstream.
        res_ready = 1'b0;
        expect_pkt(40'h100, 32'h100, 1'b0, 1'b0, 5'd1, 1'b0, 16'd4);
        send_beat(32'h100, 4'hF, 1'b1);
        tdata = 32'h5; tstrb = 4'hF; tvalid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t4_hold_tready", 64'(tready_a), 64'd0);
            check("t4_hold_res", 64'({valid_a, count_a, sum_a}), {1'b1, 5'd1, 40'h100});
        end
        @(posedge clk); #1;
        res_ready = 1'b1;
        @(posedge clk); #1;
        check("t4_tready_after", 64'(tready_a), 64'd1);
        expect_pkt(40'd11, 32'd11, 1'b0, 1'b0, 5'd2, 1'b0, 16'd5);
        send_beat(32'h5, 4'hF, 1'b0);
        send_beat(32'h6, 4'hF, 1'b1);
        @(posedge clk); #1;

        // Enable dropped for 3 cycles mid-packet.
        expect_pkt(40'hA0, 32'hA0, 1'b0, 1'b0, 5'd4, 1'b0, 16'd6);
        send_beat(32'h10, 4'hF, 1'b0);
        send_beat(32'h20, 4'hF, 1'b0);
        enable = 1'b0;
        tdata = 32'h30; tstrb = 4'hF; tvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5_paused", 64'({tready_a, valid_a}), 64'd0);
        end
        @(posedge clk); #1;
        enable = 1'b1;
        send_beat(32'h30, 4'hF, 1'b0);
        send_beat(32'h40, 4'hF, 1'b1);
        @(posedge clk); #1;

        // Asynchronous reset mid-packet, then in HOLD, then a fresh packet.
        send_beat(32'h77, 4'hF, 1'b0);
        send_beat(32'h88, 4'hF, 1'b0);
        #2;
        areset = 1'b1;
        #1;
        check_all_zero("t6_mid");
        @(posedge clk); #3;
        areset = 1'b0;
        @(posedge clk); #1;
        res_ready = 1'b0;
        send_beat(32'h9, 4'hF, 1'b1);
        check("t6_in_hold", 64'(valid_a), 64'd1);
        #2;
        areset = 1'b1;
        #1;
        check_all_zero("t6_hold");
        @(posedge clk); #3;
        areset = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        expect_pkt(40'd12, 32'd12, 1'b0, 1'b0, 5'd2, 1'b0, 16'd1);
        send_beat(32'h5, 4'hF, 1'b0);
        send_beat(32'h7, 4'hF, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_packet_accumulator.md
Name: axis_packet_accumulator

Overview:
- AXI-Stream slave stage that sits directly downstream of generator_fifo_wrapper and consumes its m00_axis stream.
- Sums the strobe-masked data words of each packet, delimited by tlast, and counts the beats.
- Presents the per-packet result on a valid/ready result port.
- Backpressures the stream while a result is waiting to be taken.

Parameters:
- DATA_SIZE, 32: stream data width; must be a multiple of 8.
- SUM_SIZE, 40: accumulator width, ≥ DATA_SIZE.
- MAX_WORDS, 16: maximum beats per packet before a forced close.
- CNT_SIZE, $clog2(MAX_WORDS+1): beat-counter width.

Ports:
- s00_axis_aclk  in  1  clock; all logic on the rising edge.
- s00_axis_areset  in  1  asynchronous, active-high reset.
- s00_axis_enable  in  1  receive enable.
- s00_axis_tdata  in  DATA_SIZE  stream data.
- s00_axis_tstrb  in  DATA_SIZE/8  byte strobes.
- s00_axis_tvalid  in  1  stream valid.
- s00_axis_tlast  in  1  last beat of packet.
- s00_axis_tready  out  1  stream ready.
- res_sum  out  SUM_SIZE  packet sum, modulo 2^SUM_SIZE.
- res_count  out  CNT_SIZE  beats in the packet.
- res_overflow  out  1  sum wrapped at least once in this packet.
- res_truncated  out  1  packet force-closed at MAX_WORDS with no tlast.
- res_valid  out  1  result valid.
- res_ready  in  1  result consumer ready.
- pkt_total  out  16  packets completed since reset; wraps.

Behaviour:
- Reset is asynchronous and active-high. While s00_axis_areset=1:
  - All outputs are 0 and state is IDLE.
  - The accumulator, beat counter and overflow flag are 0.
  - Any partial packet is discarded. Reset release takes effect at the next rising edge.
- States:
  - IDLE: no beat of the current packet accepted yet.
  - ACCUM: at least one beat accepted.
  - HOLD: result registered and waiting to be taken.
- s00_axis_tready = s00_axis_enable && (state != HOLD). It is combinational from a registered state and the enable input.
- A beat is accepted when s00_axis_tvalid && s00_axis_tready at the rising edge. No other condition changes the accumulator.
- Masked word: byte i = tdata[8i+7:8i] if tstrb[i], else 0. The masked word is zero-extended to SUM_SIZE.
- On each accepted beat:
  - acc <= acc + masked.
  - cnt <= cnt + 1.
  - ovf <= ovf | carry out of SUM_SIZE.
  - In IDLE, acc, cnt and ovf start from 0 (the first beat loads them directly).
  - IDLE goes to ACCUM.
- Closing a packet: an accepted beat with tlast=1, or an accepted beat that makes cnt == MAX_WORDS, closes the packet. On that edge:
  - res_sum, res_count and res_overflow are loaded with the post-beat values.
  - res_truncated is set = !tlast.
  - res_valid <= 1 and pkt_total increments.
  - acc, cnt and ovf clear and state goes to HOLD.
  - Latency: res_valid is high in the cycle after the closing beat's edge.
- A single-beat packet (tlast on the first beat) goes IDLE → HOLD directly with res_count=1.
- HOLD:
  - tready=0, so no beats are accepted.
  - Result outputs are stable until the handshake.
  - When res_valid && res_ready: res_valid <= 0 and state goes to IDLE; tready rises in the following cycle. Result data regs keep their last values.
- res_ready held high makes HOLD last exactly one cycle, giving one bubble per packet.
- s00_axis_enable=0 mid-packet pauses acceptance only; the partial packet is kept and accumulation resumes when enable returns.
- tvalid high with tready low is not an error; the beat waits upstream.
- A beat with tstrb=0 still counts as a beat and adds 0.
- pkt_total wraps from 0xFFFF to 0.

Test Plan:
1. Reset, enable=1, res_ready=1; send 4 beats 0x1,0x2,0x3,0x4 with tstrb=0xF and tlast on the 4th → res_valid for 1 cycle with res_sum=10, res_count=4, overflow=0, truncated=0, pkt_total=1; tready low exactly 1 cycle.
2. Beats 0xAABBCCDD with tstrb=0x5, then 0x11223344 with tstrb=0xF and tlast → res_sum=0x00BB00DD+0x11223344=0x11DD3421, res_count=2.
3. MAX_WORDS=16, send 16 beats of 0xFFFFFFFF with no tlast → closes on the 16th beat with res_truncated=1, res_count=16, res_sum=0xFFFFFFFF0 (SUM_SIZE=40), overflow=0. Repeat with SUM_SIZE=32 → overflow=1, res_sum=0xFFFFFFF0.
4. res_ready=0 after a packet closes: tready stays 0 and res_* stay stable for 10 cycles while tvalid=1; raise res_ready → handshake, tready=1 the next cycle, next packet accumulates from 0.
5. Toggle enable low for 3 cycles mid-packet, then restore → no beats accepted while low, final sum equals the uninterrupted sum.
6. Assert areset asynchronously, away from a clock edge, mid-packet and in HOLD → all outputs 0 immediately; after release, a fresh 2-beat packet 5,7 yields res_sum=12, res_count=2, pkt_total=1.
